// File: rtl/rr_arbiter_if.sv
// ============================================================================
//  Module      : rr_arbiter_if
//  Description : Request/grant bundle between requesters, arbiter and consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_if #(
    parameter int g_num_ports      = 22,
    parameter int g_num_ports_log2 = 5
);

    logic                        next_i;
    logic [g_num_ports-1:0]      request_i;
    logic [g_num_ports_log2-1:0] grant_o;
    logic                        grant_valid_o;

    // Requester/consumer side
    modport master (
        output next_i,
        output request_i,
        input  grant_o,
        input  grant_valid_o
    );

    // Arbiter side
    modport slave (
        input  next_i,
        input  request_i,
        output grant_o,
        output grant_valid_o
    );

endinterface : rr_arbiter_if

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter with registered, held grant index.
//                Optional macro RR_ARB_MASK_ACCEPTED_EN masks the just-accepted
//                port out of the arbitration that follows its acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int g_num_ports      = 22,
    parameter int g_num_ports_log2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    rr_arbiter_if.slave bus
);

    localparam logic [g_num_ports_log2-1:0] c_last_port =
        g_num_ports_log2'(g_num_ports - 1);

    logic [g_num_ports_log2-1:0] grant_q;
    logic [g_num_ports_log2-1:0] grant_d;
    logic [g_num_ports_log2-1:0] last_q;
    logic [g_num_ports_log2-1:0] last_d;
    logic                        valid_q;
    logic                        valid_d;

    logic                        w_arbitrate;
    logic [g_num_ports-1:0]      w_mask;
    logic [g_num_ports-1:0]      w_req_search;
    logic                        w_found;
    logic [g_num_ports_log2-1:0] w_winner;

    assign w_arbitrate = ~valid_q | bus.next_i;

`ifdef RR_ARB_MASK_ACCEPTED_EN
    // Hide the port being accepted so a late-clearing requester is not re-granted
    assign w_mask = (valid_q && bus.next_i)
                  ? ({{(g_num_ports-1){1'b0}}, 1'b1} << grant_q)
                  : '0;
`else
    assign w_mask = '0;
`endif

    assign w_req_search = bus.request_i & ~w_mask;

    // Search starts just after the last-served port and wraps modulo N back to it
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = last_q;
        for (int i = 1; i <= g_num_ports; i++) begin
            idx = int'(last_q) + i;
            if (idx >= g_num_ports) begin
                idx = idx - g_num_ports;
            end
            if (!w_found && w_req_search[idx]) begin
                w_found  = 1'b1;
                w_winner = idx[g_num_ports_log2-1:0];
            end
        end
    end

    always_comb begin
        grant_d = grant_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (w_arbitrate) begin
            if (w_found) begin
                grant_d = w_winner;
                valid_d = 1'b1;
                last_d  = w_winner;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            last_q  <= c_last_port;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.grant_o       = grant_q;
    assign bus.grant_valid_o = valid_q;

endmodule : rr_arbiter

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
//  Module      : tb_rr_arbiter
//  Description : Self-checking bench for rr_arbiter with a priority-queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter;

    localparam int N = 22;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_if #(.g_num_ports(N), .g_num_ports_log2(W)) bus ();

    rr_arbiter #(.g_num_ports(N), .g_num_ports_log2(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: ports listed in current priority order; granting k rotates k to the back
    int prio[$];
    bit mV;
    int mG;

    function automatic void model_reset();
        prio.delete();
        for (int i = 0; i < N; i++) prio.push_back(i);
        mV = 1'b0;
        mG = 0;
    endfunction

    function automatic void model_edge(logic [N-1:0] req, logic nx);
        logic [N-1:0] cand;
        int k;
        int p;
        if (mV && !nx) return;
        cand = req;
`ifdef RR_ARB_MASK_ACCEPTED_EN
        if (mV && nx) cand[mG] = 1'b0;
`endif
        k = -1;
        foreach (prio[i]) if (k < 0 && cand[prio[i]]) k = prio[i];
        if (k < 0) begin
            mV = 1'b0;
            return;
        end
        mG = k;
        mV = 1'b1;
        do begin
            p = prio.pop_front();
            prio.push_back(p);
        end while (p != k);
    endfunction

    // One clock: inputs sampled at the edge, outputs observed 1 time unit later
    task automatic tick();
        logic [N-1:0] r;
        logic         n;
        r = bus.request_i;
        n = bus.next_i;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(r, n);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        bus.request_i = '0;
        bus.next_i    = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.request_i = '0;
        bus.next_i    = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.grant_valid_o !== 1'b0 || bus.grant_o !== '0) begin
            errors++;
            $display("FAIL reset_initial: got valid=%b grant=%0d, expected valid=0 grant=0",
                     bus.grant_valid_o, bus.grant_o);
        end
        tick();
        tick();
        rst = 1'b0;
        bus.request_i = N'(32'h6);
        tick();
        tick();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_o !== W'(1)) begin
            errors++;
            $display("FAIL reset_pre_grant: got valid=%b grant=%0d, expected valid=1 grant=1",
                     bus.grant_valid_o, bus.grant_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.grant_valid_o !== 1'b0 || bus.grant_o !== '0) begin
            errors++;
            $display("FAIL reset_async: got valid=%b grant=%0d, expected valid=0 grant=0",
                     bus.grant_valid_o, bus.grant_o);
        end
        tick();
        rst = 1'b0;
        bus.request_i = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.grant_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: got valid=%b, expected valid=0", bus.grant_valid_o);
            end
        end
    endtask

    task automatic test_sequence();
        int exp_list[9] = '{0, 3, 7, 8, 9, 10, 13, 15, 17};
        bus.request_i = N'(32'h2A789);
        bus.next_i    = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (bus.grant_valid_o !== 1'b1 || bus.grant_o !== W'(exp_list[i])) begin
                errors++;
                $display("FAIL seq_grant[%0d]: got valid=%b grant=%0d, expected valid=1 grant=%0d",
                         i, bus.grant_valid_o, bus.grant_o, exp_list[i]);
            end
            bus.request_i[exp_list[i]] = 1'b0;
            bus.next_i = bus.grant_valid_o;
        end
        tick();
        checks++;
        if (bus.grant_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL seq_drain: got valid=%b, expected valid=0", bus.grant_valid_o);
        end
        bus.next_i = 1'b0;
    endtask

    task automatic test_wrap();
        int exp_list[2] = '{20, 2};
        bus.request_i = '0;
        bus.request_i[2]  = 1'b1;
        bus.request_i[20] = 1'b1;
        bus.next_i = bus.grant_valid_o;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.grant_valid_o !== 1'b1 || bus.grant_o !== W'(exp_list[i])) begin
                errors++;
                $display("FAIL wrap_grant[%0d]: got valid=%b grant=%0d, expected valid=1 grant=%0d",
                         i, bus.grant_valid_o, bus.grant_o, exp_list[i]);
            end
            bus.request_i[exp_list[i]] = 1'b0;
            bus.next_i = bus.grant_valid_o;
        end
        tick();
        checks++;
        if (bus.grant_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain: got valid=%b, expected valid=0", bus.grant_valid_o);
        end
        bus.next_i = 1'b0;
    endtask

    task automatic test_hold();
        reset_pulse();
        bus.request_i = N'(32'hA);
        bus.next_i    = 1'b0;
        tick();
        for (int c = 0; c < 11; c++) begin
            checks++;
            if (bus.grant_valid_o !== 1'b1 || bus.grant_o !== W'(1)) begin
                errors++;
                $display("FAIL hold[%0d]: got valid=%b grant=%0d, expected valid=1 grant=1",
                         c, bus.grant_valid_o, bus.grant_o);
            end
            if (c < 10) tick();
        end
        bus.next_i = 1'b1;
        tick();
        bus.next_i = 1'b0;
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_o !== W'(3)) begin
            errors++;
            $display("FAIL hold_accept: got valid=%b grant=%0d, expected valid=1 grant=3",
                     bus.grant_valid_o, bus.grant_o);
        end
        bus.request_i = '0;
        tick();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_o !== W'(3)) begin
            errors++;
            $display("FAIL hold_no_withdraw: got valid=%b grant=%0d, expected valid=1 grant=3",
                     bus.grant_valid_o, bus.grant_o);
        end
        bus.next_i = 1'b1;
        tick();
        bus.next_i = 1'b0;
    endtask

    task automatic test_fairness();
        int cnt[N];
        reset_pulse();
        foreach (cnt[i]) cnt[i] = 0;
        bus.request_i = '1;
        bus.next_i    = 1'b1;
        for (int c = 0; c <= N; c++) begin
            tick();
            checks++;
            if (bus.grant_valid_o !== 1'b1 || bus.grant_o !== W'(c % N)) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got valid=%b grant=%0d, expected valid=1 grant=%0d",
                         c, bus.grant_valid_o, bus.grant_o, c % N);
            end
            if (c < N && int'(bus.grant_o) < N) cnt[bus.grant_o]++;
        end
        for (int p = 0; p < N; p++) begin
            checks++;
            if (cnt[p] != 1) begin
                errors++;
                $display("FAIL fair_count[%0d]: got %0d grants, expected 1", p, cnt[p]);
            end
        end
        bus.request_i = '0;
        tick();
        bus.next_i = 1'b0;
    endtask

    task automatic test_single();
        logic exp_v;
        reset_pulse();
        bus.request_i = '0;
        bus.request_i[5] = 1'b1;
        bus.next_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
`ifdef RR_ARB_MASK_ACCEPTED_EN
            exp_v = (c % 2 == 0);
`else
            exp_v = 1'b1;
`endif
            checks++;
            if (bus.grant_valid_o !== exp_v || bus.grant_o !== W'(5)) begin
                errors++;
                $display("FAIL single[%0d]: got valid=%b grant=%0d, expected valid=%b grant=5",
                         c, bus.grant_valid_o, bus.grant_o, exp_v);
            end
        end
        bus.request_i = '0;
        tick();
        bus.next_i = 1'b0;
    endtask

    task automatic test_random();
        reset_pulse();
        for (int c = 0; c < 400; c++) begin
            bus.request_i = N'($urandom & $urandom & $urandom);
            bus.next_i    = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (bus.grant_valid_o !== mV || bus.grant_o !== W'(mG) || int'(bus.grant_o) >= N) begin
                errors++;
                $display("FAIL random[%0d]: got valid=%b grant=%0d, expected valid=%b grant=%0d",
                         c, bus.grant_valid_o, bus.grant_o, mV, mG);
            end
        end
        bus.request_i = '0;
        bus.next_i    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_hold();
        test_fairness();
        test_single();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter

`default_nettype wire

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Parameterisable round-robin arbiter for the switch core. It selects one of g_num_ports request lines and presents the winner's index as a registered grant.
- The grant is held until the consumer acknowledges it with next_i.
- Priority rotates so that the port after the most recently granted one has highest priority. This guarantees starvation-free service for all requesters.

Parameters:
- g_num_ports, 22, number of request inputs (N); legal range 2..64.
- g_num_ports_log2, 5, width of the grant index; must satisfy 2**g_num_ports_log2 >= g_num_ports.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clock clk.
- next_i  input  1  consumer accepts the current grant; ignored while grant_valid_o=0.
- request_i  input  g_num_ports  per-port request, level-sensitive; bit k = port k requesting.
- grant_o  output  g_num_ports_log2  index of the granted port; registered.
- grant_valid_o  output  1  grant_o holds a valid grant; registered.

Behaviour:
- Internal state:
  - grant register G (g_num_ports_log2 bits).
  - valid flag V.
  - last-served pointer L (g_num_ports_log2 bits).
- Reset (asynchronous, while rst=1): G=0, V=0, L=N-1, so port 0 has highest priority after reset.
- Arbitration cycle: occurs on any rising edge where V=0, or where V=1 and next_i=1.
  - Search request_i starting at index (L+1) mod N, ascending, wrapping from N-1 to 0, and ending at L inclusive.
  - First set bit k found: G<=k, V<=1, L<=k.
  - No bit set: V<=0; G and L keep their values.
- Hold: if V=1 and next_i=0, G, V and L are unchanged regardless of request_i. A grant is never withdrawn, even if its request drops.
- Latency: a request arriving while idle (V=0) is sampled at edge n, and grant_valid_o=1 from edge n onward, i.e. one clock of latency.
- Back-to-back grants: with next_i tied to grant_valid_o and continuous requests, a new grant is issued on every clock with no bubble.
- Single requester: if only port k is requesting and its grant is accepted, the wrap search ends at L=k, so k is re-granted on the next cycle. Compile-time masking of this case is covered under Optional Feature.
- Wrap-around is modulo N, not 2**g_num_ports_log2. Indices >= N are never produced.
- The search is purely combinational from request_i and L, followed by registers. No combinational path exists from inputs to outputs.
- A request change on the same edge as next_i is sampled at that edge. A requester deasserting one cycle after being granted is therefore safe, because rotation moves priority past it.

Optional Feature:
- Macro: RR_ARB_MASK_ACCEPTED_EN.
- Defined: during an arbitration triggered by V=1 and next_i=1, bit G of request_i is masked out of the search.
  - If the accepted port is the only requester, V<=0 for one cycle.
  - It can be re-granted on the following arbitration (V=0 path, no mask).
  - This prevents a double grant when the requester clears its request one cycle late.
- Not defined: no masking; behaviour exactly as in Behaviour.

Test Plan:
- Reset: assert rst mid-operation with V=1 -> grant_valid_o=0 and grant_o=0 immediately (asynchronous). After release with request_i=0 -> grant_valid_o stays 0.
- N=22, next_i=grant_valid_o, request_i=0x2A789 (bits 0,3,7,8,9,10,13,15,17), bench clears each granted bit one cycle after the grant -> grants 0,3,7,8,9,10,13,15,17 on consecutive clocks, then grant_valid_o=0.
- Hold: request_i=0b1010, next_i=0 -> grant_o=1 and valid stays asserted for 10 cycles. Pulse next_i -> grant_o=3 on the next edge.
- Wrap: after grant 17, raise bit 2 and bit 20 -> next grant 20, then 2.
- Fairness: all 22 bits held high, next_i=1 -> grants 0..21 then 0 again, each port exactly once per 22 cycles.
- Single requester, only bit 5 held, next_i=1:
  - Macro undefined -> grant 5 every cycle.
  - RR_ARB_MASK_ACCEPTED_EN defined -> grant 5 valid on alternate cycles.
